// File: rtl/audio_pkg.sv
// Shared audio constants and the VCA sequencing states.
// Used by the envelope, VCA and mixer blocks.
package audio_pkg;

    localparam int BITDEPTH = 14;
    localparam int VOLBITS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } vca_state_t;

endpackage

// File: rtl/serial_mult.sv
// Shift-add serial multiplier: signed sample times unsigned volume.
// One partial product per clk, result is the product shifted right by VOLBITS.
module serial_mult
    import audio_pkg::*;
#(
    parameter int BITDEPTH = audio_pkg::BITDEPTH,
    parameter int VOLBITS  = audio_pkg::VOLBITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [BITDEPTH-1:0] mcand_in,
    input  logic        [VOLBITS-1:0]  mplier_in,
    output logic                       busy,
    output logic                       done,
    output logic signed [BITDEPTH-1:0] product
);

    localparam int AW = BITDEPTH + VOLBITS;
    localparam int CW = (VOLBITS > 1) ? $clog2(VOLBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(VOLBITS - 1);

    vca_state_t state;
    vca_state_t state_next;

    logic signed [AW-1:0]       acc;
    logic signed [BITDEPTH-1:0] mcand;
    logic        [VOLBITS-1:0]  mplier;
    logic        [CW-1:0]       cnt;
    logic signed [AW-1:0]       mcand_ext;
    logic signed [AW-1:0]       addend;

    // Sign-extended multiplicand aligned to the current bit weight
    always_comb begin
        mcand_ext = {{VOLBITS{mcand[BITDEPTH-1]}}, mcand};
        addend    = mcand_ext <<< cnt;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = MUL;
            MUL:  if (cnt == LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Busy covers both the accumulate phase and the output cycle
    always_comb begin
        busy = (state != IDLE);
    end

    // Operand latch, accumulate and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= mcand_in;
                        mplier <= mplier_in;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    if (mplier[cnt]) begin
                        acc <= acc + addend;
                    end
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    product <= acc[AW-1:VOLBITS];
                    done    <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/voice_vca.sv
// Voice VCA: scales one oscillator sample by the envelope volume per sample_clock.
// Optional volume slew limiting is built when VCA_SMOOTH_EN is defined.
module voice_vca
    import audio_pkg::*;
#(
    parameter int BITDEPTH  = audio_pkg::BITDEPTH,
    parameter int VOLBITS   = audio_pkg::VOLBITS,
    parameter int SLEW_STEP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_clock,
    input  logic signed [BITDEPTH-1:0] sample_in,
    input  logic        [VOLBITS-1:0]  volume,
    output logic signed [BITDEPTH-1:0] sample_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    if (SLEW_STEP < 1 || SLEW_STEP >= (1 << VOLBITS)) begin : g_bad_step
        $error("voice_vca: SLEW_STEP out of range");
    end

    logic                 sc_q;
    logic                 start_edge;
    logic                 accept;
    logic [VOLBITS-1:0]   mult_vol;

    // Rising-edge detect of the sample-rate clock; starts high so a
    // sample_clock already high at reset release is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q <= 1'b1;
        end else begin
            sc_q <= sample_clock;
        end
    end

    // An edge is only accepted while the multiplier is idle
    always_comb begin
        start_edge = sample_clock & ~sc_q;
        accept     = start_edge & ~busy;
    end

    // Sticky flag for edges that arrive while a multiply is running
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (start_edge && busy) begin
            overrun <= 1'b1;
        end
    end

`ifdef VCA_SMOOTH_EN
    localparam logic [VOLBITS-1:0] STEP = VOLBITS'(SLEW_STEP);

    logic [VOLBITS-1:0] vol_eff;
    logic [VOLBITS-1:0] vol_next;

    // Move the effective volume toward the target by at most STEP
    always_comb begin
        vol_next = vol_eff;
        if (volume > vol_eff) begin
            if ((volume - vol_eff) <= STEP) vol_next = volume;
            else vol_next = vol_eff + STEP;
        end else if (volume < vol_eff) begin
            if ((vol_eff - volume) <= STEP) vol_next = volume;
            else vol_next = vol_eff - STEP;
        end
    end

    // Effective volume advances once per accepted operation
    always_ff @(posedge clk) begin
        if (rst) begin
            vol_eff <= '0;
        end else if (accept) begin
            vol_eff <= vol_next;
        end
    end

    assign mult_vol = vol_next;
`else
    assign mult_vol = volume;
`endif

    serial_mult #(
        .BITDEPTH (BITDEPTH),
        .VOLBITS  (VOLBITS)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .mcand_in  (sample_in),
        .mplier_in (mult_vol),
        .busy      (busy),
        .done      (out_valid),
        .product   (sample_out)
    );

endmodule

// File: tb/tb_voice_vca.sv
// Directed self-checking bench for voice_vca.
// Inputs driven on negedge, outputs sampled 1ns after posedge.
`timescale 1ns/1ps
module tb_voice_vca;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_clock = 1'b0;
    logic signed [13:0] sample_in = '0;
    logic        [7:0]  volume = '0;
    logic signed [13:0] sample_out;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int n_checks = 0;
    int n_fail   = 0;

    voice_vca dut (
        .clk          (clk),
        .rst          (rst),
        .sample_clock (sample_clock),
        .sample_in    (sample_in),
        .volume       (volume),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Start one operation and wait for its valid pulse. lat counts
    // posedges from the start edge (edge 1) to the one raising out_valid.
    task automatic run_op(input logic signed [13:0] sin, input logic [7:0] vol,
                          output int res, output int lat);
        @(negedge clk);
        sample_in = sin;
        volume = vol;
        sample_clock = 1'b1;
        res = 0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            sample_clock = 1'b0;
            if (out_valid) begin
                lat = i;
                res = sample_out;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_clock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        chk("reset_sample_out", sample_out, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);
    endtask

    task automatic test_basic();
        int res, lat;
        run_op(14'sd8191, 8'd255, res, lat);
        chk("basic_result", res, 8159);
        chk("basic_latency", lat, 10);
        @(posedge clk);
        #1;
        chk("basic_valid_one_cycle", out_valid, 0);
        chk("basic_hold", sample_out, 8159);
        chk("basic_busy_clear", busy, 0);
    endtask

    task automatic test_signed();
        int sins [7] = '{-8192, -1, -5000, -8192, -3000, 8191, 1234};
        int vols [7] = '{128, 1, 0, 255, 77, 0, 64};
        int exps [7] = '{-4096, -1, 0, -8160, -903, 0, 308};
        int res, lat;
        for (int i = 0; i < 7; i++) begin
            run_op(14'(sins[i]), 8'(vols[i]), res, lat);
            chk($sformatf("signed_%0d_result", i), res, exps[i]);
            chk($sformatf("signed_%0d_latency", i), lat, 10);
        end
    endtask

    task automatic test_operand_latch();
        int res = 0;
        int lat = 0;
        @(negedge clk);
        sample_in = 14'sd1000;
        volume = 8'd200;
        sample_clock = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            sample_clock = 1'b0;
            sample_in = 14'($urandom);
            volume = 8'($urandom);
            if (out_valid) begin
                lat = i;
                res = sample_out;
                break;
            end
        end
        chk("latch_result", res, 781);
        chk("latch_latency", lat, 10);
    endtask

    task automatic test_overrun();
        int res = 0;
        int lat = 0;
        int nv;
        chk("overrun_initial", overrun, 0);
        @(negedge clk);
        sample_in = 14'sd8191;
        volume = 8'd255;
        sample_clock = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            sample_clock = (i == 2);
            if (out_valid) begin
                lat = i;
                res = sample_out;
                break;
            end
        end
        chk("overrun_first_result", res, 8159);
        chk("overrun_first_latency", lat, 10);
        chk("overrun_set", overrun, 1);
        count_valids(12, nv);
        chk("overrun_no_extra_valid", nv, 0);
        run_op(14'sd100, 8'd128, res, lat);
        chk("overrun_next_result", res, 50);
        chk("overrun_sticky", overrun, 1);
    endtask

    task automatic test_done_edge();
        int lat = 0;
        int nv;
        do_reset();
        @(negedge clk);
        sample_in = 14'sd2000;
        volume = 8'd128;
        sample_clock = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            sample_clock = (i == 8);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk("done_edge_latency", lat, 10);
        chk("done_edge_result", sample_out, 1000);
        chk("done_edge_overrun", overrun, 1);
        sample_clock = 1'b0;
        count_valids(12, nv);
        chk("done_edge_no_extra_valid", nv, 0);
    endtask

    task automatic test_reset_mid();
        int nv;
        @(negedge clk);
        sample_in = 14'sd3000;
        volume = 8'd100;
        sample_clock = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            sample_clock = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_sample_out", sample_out, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_overrun", overrun, 0);
        count_valids(15, nv);
        chk("midrst_no_valid", nv, 0);
    endtask

    task automatic test_sc_high_release();
        int nv, res, lat;
        @(negedge clk);
        rst = 1'b1;
        sample_clock = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_valids(15, nv);
        chk("schigh_no_valid", nv, 0);
        chk("schigh_busy", busy, 0);
        @(negedge clk);
        sample_clock = 1'b0;
        run_op(-14'sd8192, 8'd128, res, lat);
        chk("schigh_next_result", res, -4096);
        chk("schigh_next_latency", lat, 10);
    endtask

    task automatic test_smooth();
        int res, lat;
        do_reset();
        run_op(14'sd4096, 8'd255, res, lat);
`ifdef VCA_SMOOTH_EN
        chk("smooth_first", res, 64);
`else
        chk("smooth_first", res, 4080);
`endif
        run_op(14'sd4096, 8'd255, res, lat);
`ifdef VCA_SMOOTH_EN
        chk("smooth_second", res, 128);
`else
        chk("smooth_second", res, 4080);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_operand_latch();
        test_overrun();
        test_done_edge();
        test_reset_mid();
        test_sc_high_release();
        test_smooth();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
